// File: rtl/pipe_scheduler_if.sv
// rtl/pipe_scheduler_if.sv - control and pipe-position bundle between game logic and the pipe scheduler
interface pipe_scheduler_if;
    logic       Start;
    logic       Lost;
    logic [9:0] PipePosX1;
    logic [9:0] PipePosY1;
    logic [9:0] PipePosX2;
    logic [9:0] PipePosY2;
    logic       Pipe2Active;
    logic       Running;
    logic       ScorePulse;

    // game side: issues start/lost, observes pipe state
    modport master (
        output Start, Lost,
        input  PipePosX1, PipePosY1, PipePosX2, PipePosY2,
        input  Pipe2Active, Running, ScorePulse
    );

    // scheduler side
    modport slave (
        input  Start, Lost,
        output PipePosX1, PipePosY1, PipePosX2, PipePosY2,
        output Pipe2Active, Running, ScorePulse
    );
endinterface

// File: rtl/pipe_scheduler.sv
// rtl/pipe_scheduler.sv - game phase FSM, scroll tick divider and two-slot pipe mover
module pipe_scheduler #(
    parameter int SCREEN_W = 800,
    parameter int TICK_DIV = 500000,
    parameter int SPAWN_X  = 288,
    parameter int BIRD_X   = 100,
    parameter int GAP_MIN  = 50,
    parameter int GAP_STEP = 50
) (
    input  logic               Clk,
    input  logic               Reset,
    pipe_scheduler_if.slave    bus
);

    localparam int          CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [9:0]  X_START   = 10'(SCREEN_W);
    localparam logic [9:0]  X_ACT     = 10'(SPAWN_X);
    localparam logic [9:0]  X_BIRD    = 10'(BIRD_X);
    localparam logic [9:0]  Y_RESET   = 10'(GAP_MIN + 4 * GAP_STEP);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOST = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [15:0]      lfsr, lfsr_nxt;
    logic [9:0]       x1, x1_nxt, y1, y1_nxt;
    logic [9:0]       x2, x2_nxt, y2, y2_nxt;
    logic             act, act_nxt;
    logic             running_q;
    logic             score_q, score_nxt;
    logic             tick;

    // Gap height for a 3-bit random code; wraps at 10 bits like the position bus
    function automatic logic [9:0] gap_y(input logic [2:0] code);
        gap_y = 10'(GAP_MIN + GAP_STEP * int'(code));
    endfunction

    // Next-state, tick divider, pipe movement and score decision
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        x1_nxt    = x1;
        y1_nxt    = y1;
        x2_nxt    = x2;
        y2_nxt    = y2;
        act_nxt   = act;
        score_nxt = 1'b0;
        tick      = 1'b0;
        lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

        unique case (state)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_nxt = ST_RUN;
                    y1_nxt    = gap_y(lfsr[2:0]);
                    x1_nxt    = X_START;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                // Lost freezes everything this cycle, including a pending tick
                if (bus.Lost) begin
                    state_nxt = ST_LOST;
                end else begin
                    tick    = (cnt == TICK_LAST);
                    cnt_nxt = tick ? '0 : cnt + 1'b1;
                    if (tick) begin
                        if (x1 == 10'd0) begin
                            x1_nxt = X_START;
                            y1_nxt = gap_y(lfsr[2:0]);
                        end else begin
                            x1_nxt = x1 - 10'd1;
                        end
                        // pipe 2 joins on the tick that lands pipe 1 on the spawn column
                        if (x1_nxt == X_ACT) begin
                            act_nxt = 1'b1;
                        end
                        // uses the pre-tick flag so pipe 2 waits one more tick
                        if (act) begin
                            if (x2 == 10'd0) begin
                                x2_nxt = X_START;
                                y2_nxt = gap_y(lfsr[5:3]);
                            end else begin
                                x2_nxt = x2 - 10'd1;
                            end
                        end
                        // a single strobe even if both pipes pass together
                        score_nxt = (x1 == X_BIRD) || (act && (x2 == X_BIRD));
                    end
                end
            end
            ST_LOST: begin
                if (bus.Start) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    x1_nxt    = X_START;
                    y1_nxt    = Y_RESET;
                    x2_nxt    = X_START;
                    y2_nxt    = Y_RESET;
                    act_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; the LFSR free-runs in every state
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lfsr      <= LFSR_SEED;
            x1        <= X_START;
            y1        <= Y_RESET;
            x2        <= X_START;
            y2        <= Y_RESET;
            act       <= 1'b0;
            running_q <= 1'b0;
            score_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lfsr      <= lfsr_nxt;
            x1        <= x1_nxt;
            y1        <= y1_nxt;
            x2        <= x2_nxt;
            y2        <= y2_nxt;
            act       <= act_nxt;
            running_q <= (state_nxt == ST_RUN);
            score_q   <= score_nxt;
        end
    end

    assign bus.PipePosX1   = x1;
    assign bus.PipePosY1   = y1;
    assign bus.PipePosX2   = x2;
    assign bus.PipePosY2   = y2;
    assign bus.Pipe2Active = act;
    assign bus.Running     = running_q;
    assign bus.ScorePulse  = score_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb/tb_pipe_scheduler.sv - self-checking bench for pipe_scheduler
module tb_pipe_scheduler;

    localparam int W  = 800;
    localparam int TD = 4;
    localparam int SP = 288;
    localparam int BX = 100;
    localparam int GM = 50;
    localparam int GS = 50;
    localparam int YR = GM + 4 * GS;

    logic Clk = 1'b0;
    logic Reset;
    int   total = 0;
    int   bad   = 0;

    always #5 Clk = ~Clk;

    pipe_scheduler_if bus ();
    pipe_scheduler_if bus_b ();

    pipe_scheduler #(
        .SCREEN_W(W), .TICK_DIV(TD), .SPAWN_X(SP),
        .BIRD_X(BX), .GAP_MIN(GM), .GAP_STEP(GS)
    ) dut (
        .Clk(Clk), .Reset(Reset), .bus(bus)
    );

    // spawn column equal to the screen width keeps both pipes on top of each other
    pipe_scheduler #(
        .SCREEN_W(10), .TICK_DIV(2), .SPAWN_X(10),
        .BIRD_X(3), .GAP_MIN(GM), .GAP_STEP(GS)
    ) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(bus_b)
    );

    // reference model: positions derived from tick counts, not from stepping X
    int          m_phase;   // 0 idle, 1 run, 2 lost
    logic [15:0] m_lfsr;
    int          m_cyc;
    int          m_t1;
    int          m_t2;
    logic        m_act;
    logic        m_score;
    logic [9:0]  m_y1;
    logic [9:0]  m_y2;

    function automatic logic [9:0] gap(input int code);
        return 10'(GM + GS * code);
    endfunction

    function automatic logic [9:0] xpos(input int t);
        return 10'(W - (t % (W + 1)));
    endfunction

    function automatic logic tick_next();
        return (m_phase == 1) && ((m_cyc % TD) == TD - 1);
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_lfsr  = 16'hACE1;
        m_cyc   = 0;
        m_t1    = 0;
        m_t2    = 0;
        m_act   = 1'b0;
        m_score = 1'b0;
        m_y1    = 10'(YR);
        m_y2    = 10'(YR);
    endtask

    task automatic model_edge(input logic st, input logic lo);
        logic [15:0] cur;
        logic [15:0] keep;
        logic        was_act;
        cur     = m_lfsr;
        m_lfsr  = (cur >> 1) ^ (cur[0] ? 16'hB400 : 16'h0000);
        m_score = 1'b0;
        case (m_phase)
            0: if (st) begin
                m_phase = 1;
                m_y1    = gap(int'(cur[2:0]));
                m_t1    = 0;
                m_cyc   = 0;
            end
            1: if (lo) begin
                m_phase = 2;
            end else begin
                if ((m_cyc % TD) == TD - 1) begin
                    was_act = m_act;
                    if (xpos(m_t1) == 0)  m_y1 = gap(int'(cur[2:0]));
                    if (xpos(m_t1) == BX) m_score = 1'b1;
                    m_t1++;
                    if (xpos(m_t1) == SP) m_act = 1'b1;
                    if (was_act) begin
                        if (xpos(m_t2) == 0)  m_y2 = gap(int'(cur[5:3]));
                        if (xpos(m_t2) == BX) m_score = 1'b1;
                        m_t2++;
                    end
                end
                m_cyc++;
            end
            default: if (st) begin
                keep = m_lfsr;
                model_reset();
                m_lfsr = keep;
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("x1", bus.PipePosX1, xpos(m_t1));
        chk("y1", bus.PipePosY1, m_y1);
        chk("x2", bus.PipePosX2, xpos(m_t2));
        chk("y2", bus.PipePosY2, m_y2);
        chk("pipe2_active", bus.Pipe2Active, m_act);
        chk("running", bus.Running, m_phase == 1);
        chk("score", bus.ScorePulse, m_score);
    endtask

    // one clock: model follows the edge, outputs checked on the falling edge
    task automatic step();
        @(posedge Clk);
        if (Reset) model_reset();
        else       model_edge(bus.Start, bus.Lost);
        @(negedge Clk);
        check_all();
    endtask

    task automatic wait_x1(input string tag, input logic [9:0] v, input int budget);
        int n;
        n = 0;
        while (bus.PipePosX1 !== v && n < budget) begin
            step();
            n++;
        end
        chk(tag, bus.PipePosX1, v);
    endtask

    task automatic pulse_start();
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
    endtask

    initial begin
        int   n;
        int   pulses;
        logic in_set;

        Reset       = 1'b1;
        bus.Start   = 1'b0;
        bus.Lost    = 1'b0;
        bus_b.Start = 1'b0;
        bus_b.Lost  = 1'b0;
        model_reset();
        @(negedge Clk);
        chk("rst_x1", bus.PipePosX1, 16'd800);
        chk("rst_y1", bus.PipePosY1, 16'd250);
        chk("rst_running", bus.Running, 16'd0);
        check_all();
        step();
        step();
        Reset = 1'b0;

        // idle: Lost ignored, LFSR phase randomized by the wait length
        repeat ($urandom_range(3, 20)) begin
            bus.Lost = 1'($urandom_range(0, 1));
            step();
        end
        bus.Lost = 1'b0;
        chk("idle_running", bus.Running, 16'd0);

        // scroll
        pulse_start();
        chk("start_x1", bus.PipePosX1, 16'd800);
        chk("start_running", bus.Running, 16'd1);
        repeat (12) step();
        chk("scroll_x1", bus.PipePosX1, 16'd797);
        chk("scroll_x2", bus.PipePosX2, 16'd800);
        chk("scroll_act", bus.Pipe2Active, 16'd0);

        // asynchronous reset in the middle of a run
        wait_x1("wait_x1_500", 10'd500, 2000);
        #2 Reset = 1'b1;
        #1;
        chk("async_x1", bus.PipePosX1, 16'd800);
        chk("async_x2", bus.PipePosX2, 16'd800);
        chk("async_y1", bus.PipePosY1, 16'd250);
        chk("async_y2", bus.PipePosY2, 16'd250);
        chk("async_act", bus.Pipe2Active, 16'd0);
        chk("async_running", bus.Running, 16'd0);
        chk("async_score", bus.ScorePulse, 16'd0);
        model_reset();
        step();
        Reset = 1'b0;
        repeat (5) step();
        chk("post_rst_idle", bus.Running, 16'd0);
        chk("post_rst_y1", bus.PipePosY1, 16'd250);

        // start held for two cycles: second cycle lands in RUN and is ignored
        bus.Start = 1'b1;
        step();
        step();
        bus.Start = 1'b0;

        // stagger
        wait_x1("wait_x1_288", 10'd288, 2500);
        chk("stagger_act", bus.Pipe2Active, 16'd1);
        chk("stagger_x2_hold", bus.PipePosX2, 16'd800);
        wait_x1("wait_x1_287", 10'd287, 10);
        chk("stagger_x2_move", bus.PipePosX2, 16'd799);

        // score strobe as pipe 1 passes the bird
        wait_x1("wait_x1_99", 10'd99, 1000);
        chk("score_on", bus.ScorePulse, 16'd1);
        step();
        chk("score_off", bus.ScorePulse, 16'd0);

        // recycle
        wait_x1("wait_x1_0", 10'd0, 500);
        wait_x1("recycle_x1", 10'd800, 10);
        in_set = (bus.PipePosY1 >= 10'd50) && (bus.PipePosY1 <= 10'd400) &&
                 ((bus.PipePosY1 % 10'd50) == 10'd0);
        chk("recycle_y1_set", in_set, 16'd1);
        chk("recycle_y1_model", bus.PipePosY1, m_y1);

        // Lost on a tick cycle beats movement and score
        wait_x1("wait_x1_100", 10'd100, 3500);
        n = 0;
        while (!tick_next() && n < 10) begin
            step();
            n++;
        end
        bus.Lost = 1'b1;
        step();
        bus.Lost = 1'b0;
        chk("lost_x1", bus.PipePosX1, 16'd100);
        chk("lost_score", bus.ScorePulse, 16'd0);
        chk("lost_running", bus.Running, 16'd0);
        repeat (10) step();
        chk("lost_frozen", bus.PipePosX1, 16'd100);
        pulse_start();
        chk("restart_x1", bus.PipePosX1, 16'd800);
        chk("restart_y1", bus.PipePosY1, 16'd250);
        chk("restart_act", bus.Pipe2Active, 16'd0);
        chk("restart_idle", bus.Running, 16'd0);
        pulse_start();
        chk("rerun_running", bus.Running, 16'd1);

        // random Start/Lost traffic against the model
        repeat (1500) begin
            bus.Start = ($urandom_range(0, 39) == 0);
            bus.Lost  = ($urandom_range(0, 79) == 0);
            step();
        end
        bus.Start = 1'b0;
        bus.Lost  = 1'b0;

        // both pipes cross the bird on the same tick
        bus_b.Start = 1'b1;
        step();
        bus_b.Start = 1'b0;
        n = 0;
        while (!(bus_b.Pipe2Active === 1'b1 && bus_b.PipePosX1 === 10'd2) && n < 200) begin
            step();
            n++;
        end
        chk("dual_x1", bus_b.PipePosX1, 16'd2);
        chk("dual_x2", bus_b.PipePosX2, 16'd2);
        chk("dual_score_on", bus_b.ScorePulse, 16'd1);
        pulses = 0;
        for (int i = 0; i < 44; i++) begin
            step();
            if (i == 0) chk("dual_score_off", bus_b.ScorePulse, 16'd0);
            if (bus_b.ScorePulse === 1'b1) pulses++;
        end
        chk("dual_pulse_count", 16'(pulses), 16'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
